int2flt_seq: RTL

Parametrised, sequential integer-to-floating-point converter: the hardware successor to the CPU's fixed 16-bit int→half conversion routine. It accepts an INT_W-bit integer in sign-magnitude or two's-complement form and produces a 1+EXP_W+MAN_W float. The datapath uses an iterative one-bit-per-cycle normaliser, round-to-nearest-even and overflow saturation. It sits beside the ALU as a multi-cycle functional unit with a start/done handshake.

---
 rtl/int2flt_pkg.sv | 25 ++
 rtl/int2flt_seq_if.sv | 30 +++
 rtl/int2flt_round.sv | 64 ++++++
 rtl/int2flt_seq.sv | 133 +++++++++++++
 4 files changed

// File: rtl/int2flt_pkg.sv
// Shared types and defaults for the sequential integer-to-float converter.
package int2flt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        NORM,
        ROUND
    } state_e;

    localparam int DEF_INT_W = 16;
    localparam int DEF_EXP_W = 5;
    localparam int DEF_MAN_W = 10;
    localparam int DEF_BIAS  = 15;

    function automatic int flt_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Shift count never exceeds INT_W-1, so clog2(INT_W) bits suffice.
    function automatic int sh_width(input int int_w);
        return $clog2(int_w);
    endfunction

endpackage

// File: rtl/int2flt_seq_if.sv
// Start/done handshake and operand/result bus of the int-to-float unit.
interface int2flt_seq_if
    import int2flt_pkg::*;
#(
    parameter int INT_W = DEF_INT_W,
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
);
    localparam int FLT_W = flt_width(EXP_W, MAN_W);

    logic             start;
    logic             twos;
    logic [INT_W-1:0] int_in;
    logic             busy;
    logic             done;
    logic [FLT_W-1:0] flt_out;
    logic             ovf;
    logic             inexact;

    modport master (
        output start, twos, int_in,
        input  busy, done, flt_out, ovf, inexact
    );

    modport slave (
        input  start, twos, int_in,
        output busy, done, flt_out, ovf, inexact
    );

endinterface

// File: rtl/int2flt_round.sv
// Combinational rounder/packer for a normalised magnitude.
// INT2FLT_RNE_EN selects round-to-nearest-even; otherwise the fraction is truncated.
module int2flt_round
    import int2flt_pkg::*;
#(
    parameter int INT_W = DEF_INT_W,
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int BIAS  = DEF_BIAS,
    parameter int SH_W  = sh_width(INT_W),
    parameter int FLT_W = flt_width(EXP_W, MAN_W)
) (
    input  logic [INT_W-1:0] mag,
    input  logic [SH_W-1:0]  sh,
    input  logic             sign,
    output logic [FLT_W-1:0] result,
    output logic             ovf,
    output logic             inexact
);
    // Bits below the hidden one, zero-padded so a guard bit always exists.
    localparam int EXT_W   = INT_W - 1 + MAN_W + 2;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    logic [EXT_W-1:0] ext;
    logic [MAN_W-1:0] frac;
    logic             guard;
    logic             sticky;
    logic             round_up;
    logic [MAN_W:0]   frac_inc;
    int               exp_pre;
    int               exp_fin;

    assign ext    = {mag[INT_W-2:0], {(MAN_W + 2){1'b0}}};
    assign frac   = ext[EXT_W-1 -: MAN_W];
    assign guard  = ext[EXT_W-1-MAN_W];
    assign sticky = |ext[EXT_W-2-MAN_W:0];

`ifdef INT2FLT_RNE_EN
    assign round_up = guard & (sticky | frac[0]);
`else
    assign round_up = 1'b0;
`endif

    assign frac_inc = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};

    // NOTE: every output gets a default before any branch so no latch can be inferred.
    always_comb begin
        result  = {sign, {(FLT_W - 1){1'b0}}};
        ovf     = 1'b0;
        inexact = 1'b0;
        exp_pre = BIAS + INT_W - 1 - int'(sh);
        exp_fin = exp_pre + int'(frac_inc[MAN_W]);
        if (mag != '0) begin
            inexact = guard | sticky;
            if (exp_fin >= EXP_MAX) begin
                ovf    = 1'b1;
                result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                result = {sign, exp_fin[EXP_W-1:0], frac_inc[MAN_W-1:0]};
            end
        end
    end

endmodule

// File: rtl/int2flt_seq.sv
// Multi-cycle integer-to-float unit: operand latch, one-bit-per-cycle normaliser, FSM.
// Rounding mode is chosen by INT2FLT_RNE_EN inside int2flt_round.
module int2flt_seq
    import int2flt_pkg::*;
#(
    parameter int INT_W = DEF_INT_W,
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int BIAS  = DEF_BIAS
) (
    input logic          clk,
    input logic          reset,
    int2flt_seq_if.slave bus
);
    localparam int SH_W  = sh_width(INT_W);
    localparam int FLT_W = flt_width(EXP_W, MAN_W);

    state_e           state_q;
    state_e           state_d;
    logic [INT_W-1:0] opnd_q;
    logic [INT_W-1:0] mag_q;
    logic [INT_W-1:0] mag_load;
    logic [SH_W-1:0]  sh_q;
    logic             twos_q;
    logic             sign_q;
    logic             done_q;
    logic [FLT_W-1:0] flt_q;
    logic             ovf_q;
    logic             inexact_q;
    logic [FLT_W-1:0] rnd_result;
    logic             rnd_ovf;
    logic             rnd_inexact;
    logic             accept;
    logic             norm_exit;

    // The done cycle is still the tail of the previous conversion, so a start there is dropped.
    assign accept = bus.start & ~done_q;

    // A zero operand leaves NORM at once, giving the same 3-cycle path as an lz=0 value.
    assign norm_exit = mag_q[INT_W-1] | (mag_q == '0);

    always_comb begin
        mag_load = {1'b0, opnd_q[INT_W-2:0]};
        if (twos_q) begin
            mag_load = opnd_q[INT_W-1] ? -opnd_q : opnd_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = LOAD;
            LOAD:    state_d = NORM;
            NORM:    if (norm_exit) state_d = ROUND;
            ROUND:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the datapath is a handful of flops, so all of it is cleared on reset, not just control.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opnd_q    <= '0;
            twos_q    <= 1'b0;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            sh_q      <= '0;
            done_q    <= 1'b0;
            flt_q     <= '0;
            ovf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            done_q <= (state_q == ROUND);
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        opnd_q <= bus.int_in;
                        twos_q <= bus.twos;
                    end
                end
                LOAD: begin
                    sign_q <= opnd_q[INT_W-1];
                    mag_q  <= mag_load;
                    sh_q   <= '0;
                end
                NORM: begin
                    if (!norm_exit) begin
                        mag_q <= mag_q << 1;
                        sh_q  <= sh_q + SH_W'(1);
                    end
                end
                ROUND: begin
                    flt_q     <= rnd_result;
                    ovf_q     <= rnd_ovf;
                    inexact_q <= rnd_inexact;
                end
                default: ;
            endcase
        end
    end

    int2flt_round #(
        .INT_W (INT_W),
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .BIAS  (BIAS),
        .SH_W  (SH_W),
        .FLT_W (FLT_W)
    ) u_round (
        .mag     (mag_q),
        .sh      (sh_q),
        .sign    (sign_q),
        .result  (rnd_result),
        .ovf     (rnd_ovf),
        .inexact (rnd_inexact)
    );

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.flt_out = flt_q;
    assign bus.ovf     = ovf_q;
    assign bus.inexact = inexact_q;

endmodule
